// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the UART program loader.
//   state_e              loader FSM states
//   HDR_BYTES/CHK_BYTES  framing sizes of the download stream
//   DEFAULT_TIMEOUT_CYC  default inter-byte timeout in clk cycles
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
    StChk,
    StDone,
    StError
  } state_e;

  localparam int unsigned HDR_BYTES           = 2;
  localparam int unsigned CHK_BYTES           = 1;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a byte stream into little-endian 32-bit words.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_byte        incoming byte
//   i_valid       i_byte is accepted this cycle
//   i_clear       restart at byte 0 (takes priority over i_valid)
//   o_word        last completed word, held between completions
//   o_word_valid  one-cycle pulse the cycle after byte 3 is accepted
//   o_last_byte   the next accepted byte completes a word
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  input  logic        i_clear,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic        o_last_byte
);

  logic [1:0]  r_cnt;
  logic [23:0] r_buf;
  logic [31:0] r_word;
  logic        r_word_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= 2'd0;
      r_buf        <= 24'd0;
      r_word       <= 32'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_cnt <= 2'd0;
      end else if (i_valid) begin
        if (r_cnt == 2'd3) begin
          r_word       <= {i_byte, r_buf};
          r_word_valid <= 1'b1;
        end else begin
          r_buf[{r_cnt, 3'b000} +: 8] <= i_byte;
        end
        // Wraps 3 -> 0 so the next word starts cleanly.
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_last_byte  = (r_cnt == 2'd3);

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses a UART download stream (2-byte little-endian word
// count, count*4 data bytes, 1 XOR checksum byte) and writes each 32-bit word
// into instruction memory. Holds the CPU (program_off=0) while loading.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           pulse: begin a new download (ignored while busy)
//   rx_valid/data   received byte strobe and value
//   rx_err          receiver framing/parity error strobe
//   program_off     1 = CPU runs, 0 = CPU held
//   uart_write_en   one-cycle instruction-memory write strobe
//   uart_addr/data  word address and data of the write
//   busy/done/error load in progress / last load good / last load aborted
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  output logic              program_off,
  output logic              uart_write_en,
  output logic [ADDR_W-1:0] uart_addr,
  output logic [31:0]       uart_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned    ToW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ToW-1:0] ToLimit = ToW'(TIMEOUT_CYC - 1);

  state_e                   r_state, w_state_next;
  logic [8*HDR_BYTES-1:0]   r_count;
  logic [ADDR_W:0]          r_idx;   // one extra bit: count may equal 2**ADDR_W
  logic [ADDR_W-1:0]        r_addr;
  logic [8*CHK_BYTES-1:0]   r_chk;
  logic [ToW-1:0]           r_to;

  logic                     w_busy;
  logic                     w_launch;
  logic                     w_accept;
  logic                     w_data_byte;
  logic                     w_last_byte;
  logic                     w_last_word;
  logic                     w_oversize;
  logic                     w_timeout;
  logic [ToW-1:0]           w_to_inc;
  logic [8*HDR_BYTES-1:0]   w_hdr_count;
  logic [31:0]              w_word;
  logic                     w_word_valid;

  assign w_busy      = (r_state == StHdr0) || (r_state == StHdr1) ||
                       (r_state == StData) || (r_state == StChk);
  assign w_launch    = start && !w_busy;
  // A byte arriving together with rx_err is discarded.
  assign w_accept    = w_busy && rx_valid && !rx_err;
  assign w_data_byte = w_accept && (r_state == StData);
  assign w_hdr_count = {rx_data, r_count[7:0]};
  assign w_oversize  = 32'(w_hdr_count) > (32'd1 << ADDR_W);
  assign w_last_word = (32'(r_idx) + 32'd1) == 32'(r_count);
  assign w_to_inc    = r_to + 1'b1;
  assign w_timeout   = (w_to_inc == ToLimit);

  word_assembler u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .i_byte       (rx_data),
    .i_valid      (w_data_byte),
    .i_clear      (w_launch),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_last_byte  (w_last_byte)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone, StError: begin
        if (start) w_state_next = StHdr0;
      end
      StHdr0, StHdr1, StData, StChk: begin
        if (rx_err) begin
          w_state_next = StError;
        end else if (rx_valid) begin
          // An accepted byte wins over a simultaneous timeout.
          case (r_state)
            StHdr0: w_state_next = StHdr1;
            StHdr1: begin
              if (w_hdr_count == '0)  w_state_next = StChk;
              else if (w_oversize)    w_state_next = StError;
              else                    w_state_next = StData;
            end
            StData: begin
              if (w_last_byte && w_last_word) w_state_next = StChk;
            end
            StChk: begin
              w_state_next = (rx_data == r_chk) ? StDone : StError;
            end
            default: ;
          endcase
        end else if (w_timeout) begin
          w_state_next = StError;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_count <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_chk   <= '0;
      r_to    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_launch) begin
        r_count <= '0;
        r_idx   <= '0;
        r_chk   <= '0;
        r_to    <= '0;
      end else if (w_busy) begin
        r_to <= w_accept ? '0 : w_to_inc;
        if (w_accept && (r_state == StHdr0)) r_count[7:0]  <= rx_data;
        if (w_accept && (r_state == StHdr1)) r_count[15:8] <= rx_data;
        if (w_data_byte) begin
          r_chk <= r_chk ^ rx_data;
          // Address is registered alongside the assembled word so both
          // appear together on the write strobe.
          if (w_last_byte) begin
            r_addr <= r_idx[ADDR_W-1:0];
            r_idx  <= r_idx + 1'b1;
          end
        end
      end
    end
  end

  assign program_off   = (r_state == StIdle) || (r_state == StDone);
  assign busy          = w_busy;
  assign done          = (r_state == StDone);
  assign error         = (r_state == StError);
  assign uart_write_en = w_word_valid;
  assign uart_addr     = r_addr;
  assign uart_data     = w_word;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: table of complete download streams plus
// directed sequences for timeout, header bounds, rx_err, start-while-busy,
// asynchronous reset and full-capacity loads (on a second, ADDR_W=2 instance).
module tb_uart_prog_loader;

  localparam int unsigned AW  = 14;
  localparam int unsigned AW2 = 2;
  localparam int unsigned TO  = 64;

  logic          clk = 1'b0;
  logic          rst, start, rx_valid, rx_err;
  logic [7:0]    rx_data;

  logic          program_off, uart_write_en, busy, done, error;
  logic [AW-1:0] uart_addr;
  logic [31:0]   uart_data;

  logic           program_off2, uart_write_en2, busy2, done2, error2;
  logic [AW2-1:0] uart_addr2;
  logic [31:0]    uart_data2;

  uart_prog_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_err(rx_err), .program_off(program_off), .uart_write_en(uart_write_en),
    .uart_addr(uart_addr), .uart_data(uart_data), .busy(busy), .done(done),
    .error(error)
  );

  uart_prog_loader #(.ADDR_W(AW2), .TIMEOUT_CYC(TO)) dut2 (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_err(rx_err), .program_off(program_off2), .uart_write_en(uart_write_en2),
    .uart_addr(uart_addr2), .uart_data(uart_data2), .busy(busy2), .done(done2),
    .error(error2)
  );

  always #5 clk = ~clk;

  // Write logs, sampled mid-cycle; a strobe held 2 cycles logs twice.
  logic [31:0] wq_a[$], wq_d[$], wq2_a[$], wq2_d[$];
  always @(negedge clk) begin
    if (uart_write_en) begin
      wq_a.push_back(32'(uart_addr));
      wq_d.push_back(uart_data);
    end
    if (uart_write_en2) begin
      wq2_a.push_back(32'(uart_addr2));
      wq2_d.push_back(uart_data2);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk) begin rx_data = b; rx_valid = 1'b1; end
    @(negedge clk) rx_valid = 1'b0;
  endtask

  task automatic clear_logs();
    wq_a.delete(); wq_d.delete(); wq2_a.delete(); wq2_d.delete();
  endtask

  typedef struct {
    string       name;
    int          n;      // stream length in bytes
    logic [95:0] s;      // stream, first byte in the most significant used byte
    logic        exp_done;
    logic        exp_err;
    int          exp_nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  x;
    logic [31:0] w;
    int          n;

    // XOR of 78 56 34 12 EF BE AD DE is 0x2A.
    vecs[0] = '{name:"happy", n:11, s:96'h02_00_78_56_34_12_EF_BE_AD_DE_2A,
                exp_done:1'b1, exp_err:1'b0, exp_nw:2, w0:32'h12345678, w1:32'hDEADBEEF};
    vecs[1] = '{name:"bad_chk", n:11, s:96'h02_00_78_56_34_12_EF_BE_AD_DE_01,
                exp_done:1'b0, exp_err:1'b1, exp_nw:2, w0:32'h12345678, w1:32'hDEADBEEF};
    vecs[2] = '{name:"empty", n:3, s:96'h00_00_00,
                exp_done:1'b1, exp_err:1'b0, exp_nw:0, w0:32'h0, w1:32'h0};
    vecs[3] = '{name:"empty_bad", n:3, s:96'h00_00_5A,
                exp_done:1'b0, exp_err:1'b1, exp_nw:0, w0:32'h0, w1:32'h0};
    vecs[4] = '{name:"oversize", n:2, s:96'h01_40,
                exp_done:1'b0, exp_err:1'b1, exp_nw:0, w0:32'h0, w1:32'h0};
    vecs[5] = '{name:"one_word", n:7, s:96'h01_00_11_22_33_44_44,
                exp_done:1'b1, exp_err:1'b0, exp_nw:1, w0:32'h44332211, w1:32'h0};

    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    #13;
    check("rst_program_off", program_off, 1);
    check("rst_write_en", uart_write_en, 0);
    check("rst_addr", uart_addr, 0);
    check("rst_data", uart_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clk) rst = 1'b0;
    tick(2);

    // ---- Table-driven complete loads ----
    foreach (vecs[i]) begin
      clear_logs();
      pulse_start();
      check({vecs[i].name, "_busy_start"}, busy, 1);
      check({vecs[i].name, "_held_start"}, program_off, 0);
      check({vecs[i].name, "_done_clr"}, done, 0);
      check({vecs[i].name, "_err_clr"}, error, 0);
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].s[8*(vecs[i].n-1-j) +: 8]);
      tick(3);
      check({vecs[i].name, "_done"}, done, vecs[i].exp_done);
      check({vecs[i].name, "_error"}, error, vecs[i].exp_err);
      check({vecs[i].name, "_program_off"}, program_off, vecs[i].exp_done);
      check({vecs[i].name, "_busy_end"}, busy, 0);
      check({vecs[i].name, "_nwrites"}, wq_a.size(), vecs[i].exp_nw);
      if (vecs[i].exp_nw > 0) begin
        check({vecs[i].name, "_addr0"}, wq_a[0], 0);
        check({vecs[i].name, "_data0"}, wq_d[0], vecs[i].w0);
      end
      if (vecs[i].exp_nw > 1) begin
        check({vecs[i].name, "_addr1"}, wq_a[1], 1);
        check({vecs[i].name, "_data1"}, wq_d[1], vecs[i].w1);
      end
    end

    // ---- Timeout: error exactly TO-1 edges after the last accepted byte ----
    clear_logs();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h12);
    n = 0;
    while (n < 200 && !error) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_cycles", n, TO - 1);
    check("timeout_nwrites", wq_a.size(), 0);
    check("timeout_held", program_off, 0);

    // ---- Header at exactly 2**ADDR_W words is accepted into DATA ----
    clear_logs();
    pulse_start();
    send_byte(8'h00); send_byte(8'h40);
    tick(2);
    check("max_hdr_busy", busy, 1);
    check("max_hdr_error", error, 0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    tick(1);
    check("max_hdr_nwrites", wq_a.size(), 1);
    check("max_hdr_data0", wq_d[0], 32'h44332211);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    // ---- rx_err mid-word aborts with no partial write ----
    clear_logs();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk) rx_err = 1'b1;
    @(negedge clk) rx_err = 1'b0;
    check("rxerr_error", error, 1);
    send_byte(8'h33); send_byte(8'h44);
    tick(2);
    check("rxerr_nwrites", wq_a.size(), 0);
    check("rxerr_held", program_off, 0);
    check("rxerr_busy", busy, 0);

    // ---- rx_valid with rx_err on the word's last byte: discarded ----
    clear_logs();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk) begin rx_data = 8'h44; rx_valid = 1'b1; rx_err = 1'b1; end
    @(negedge clk) begin rx_valid = 1'b0; rx_err = 1'b0; end
    tick(2);
    check("valid_err_error", error, 1);
    check("valid_err_nwrites", wq_a.size(), 0);

    // ---- start while busy is ignored ----
    clear_logs();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    pulse_start();
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h44);
    tick(2);
    check("restart_done", done, 1);
    check("restart_nwrites", wq_a.size(), 1);
    check("restart_data0", wq_d[0], 32'h44332211);

    // ---- Asynchronous reset during the write strobe ----
    clear_logs();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    check("arst_we_before", uart_write_en, 1);
    rst = 1'b1;
    #1;
    check("arst_write_en", uart_write_en, 0);
    check("arst_program_off", program_off, 1);
    check("arst_addr", uart_addr, 0);
    check("arst_data", uart_data, 0);
    check("arst_busy", busy, 0);
    check("arst_error", error, 0);
    @(negedge clk) rst = 1'b0;
    tick(1);
    clear_logs();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    tick(2);
    check("arst_reload_done", done, 1);
    check("arst_reload_nwrites", wq_a.size(), 0);

    // ---- Capacity on ADDR_W=2: 4 words legal, final write at addr 3 ----
    clear_logs();
    pulse_start();
    send_byte(8'h04); send_byte(8'h00);
    x = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      b = 8'(k);
      x = x ^ b;
      send_byte(b);
    end
    send_byte(x);
    tick(2);
    check("cap_done", done2, 1);
    check("cap_nwrites", wq2_a.size(), 4);
    for (int k = 0; k < 4; k++) begin
      w = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
      if (k < wq2_a.size()) begin
        check($sformatf("cap_addr%0d", k), wq2_a[k], k);
        check($sformatf("cap_data%0d", k), wq2_d[k], w);
      end
    end

    // ---- Capacity + 1 on ADDR_W=2 is rejected after the header ----
    pulse_start();
    send_byte(8'h05); send_byte(8'h00);
    tick(1);
    check("cap_over_error", error2, 1);
    check("cap_over_wide_ok", error, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
